mem_block_responder: RTL and testbench
======================================

Name: mem_block_responder

Overview:
- Main-memory responder for the memory-side port of the 2-way set-associative cache (`stage1`).
- Answers the cache's `rd_mem` (refill) and `wr_mem` (write-back) requests. Each request is a 4-beat burst of `DATA_W`-bit bytes on the shared bidirectional `data_mem` bus.
- Paces each transfer with `ready_mem` and a programmable access latency.
- Used as the memory model in cache benches and as the memory-side endpoint in the integrated system.

Parameters:
- `ADDR_W`, 9, byte address width; storage depth = 2**`ADDR_W` bytes.
- `DATA_W`, 8, data bus width.
- `LATENCY`, 4, wait cycles between request acceptance and first beat; legal range 1..15.

Ports:
- `clock` in 1: single clock; all logic on posedge.
- `reset_n` in 1: asynchronous active-low reset.
- `addr_mem` in `ADDR_W`: request address from cache; bits [1:0] ignored (block aligned).
- `rd_mem` in 1: block read (refill) request, level.
- `wr_mem` in 1: block write (write-back) request, level.
- `data_mem` inout `DATA_W`: shared data bus; responder drives only during RD_BURST, else high-Z.
- `ready_mem` out 1: high = idle or beat valid; low = access in progress.

Behaviour:
- Reset (async, `reset_n`=0): state IDLE, `ready_mem`=1, `data_mem`=Z, beat counter=0, latency counter=0, latched base=0. Storage array is not reset.
- Reset asserted mid-transaction aborts it immediately: no further array writes, bus released within the same reset assertion.
- State machine: IDLE, RD_WAIT, RD_BURST, WR_WAIT, WR_BURST, HOLD.
- IDLE:
  - At posedge with `wr_mem`=1: latch base = {`addr_mem`[`ADDR_W`-1:2], 2'b00}, go to WR_WAIT.
  - Else at posedge with `rd_mem`=1: latch base, go to RD_WAIT.
  - Write has priority when both are high.
  - `ready_mem` goes to 0 in the cycle after acceptance.
- RD_WAIT / WR_WAIT:
  - `ready_mem`=0; latency counter counts 0..`LATENCY`-1.
  - After exactly `LATENCY` cycles in the wait state, move to the burst state.
- RD_BURST (4 cycles):
  - `ready_mem`=1; `data_mem` = mem[base+beat], beat = 0,1,2,3, one beat per cycle, registered output.
  - Cache samples each beat at the posedge ending that cycle.
- WR_BURST (4 cycles):
  - `ready_mem`=1; at each posedge mem[base+beat] <= `data_mem`.
  - Cache drives beat k in the k-th cycle after `ready_mem` rises.
- After beat 3 of either burst, go to HOLD.
- HOLD:
  - `ready_mem`=1, bus Z.
  - Return to IDLE once `rd_mem`=0 and `wr_mem`=0 are sampled. A request still held high is never re-accepted as a new transaction.
- Beat counter is 2 bits and wraps 3->0 at burst end. Addresses never cross a block, so no carry into base.
- `addr_mem`, `rd_mem` and `wr_mem` changes after acceptance are ignored until HOLD.
- Latency to first read beat: `LATENCY`+1 cycles after the accepting posedge. Total read transaction: `LATENCY`+1+4 cycles before HOLD.
- Bus contention rule: the responder never drives `data_mem` while `wr_mem`=1 or in any state other than RD_BURST.

Optional Feature:
- Macro `MEM_PROTO_CHK_EN`. When defined:
  - Adds output port `proto_err` (1 bit), reset 0, sticky until `reset_n`.
  - Sets if, in RD_WAIT/RD_BURST, `rd_mem` drops to 0.
  - Sets if, in WR_WAIT/WR_BURST, `wr_mem` drops to 0.
  - Sets if `rd_mem` and `wr_mem` are both 1 in IDLE.
  - The transaction still completes normally.
- When undefined: no port, no check logic, identical functional behaviour.

Test Plan:
- Reset:
  - Hold `reset_n`=0 for 4 cycles -> `ready_mem`=1, `data_mem`=Z.
  - Release -> IDLE; stays idle with `rd_mem`=`wr_mem`=0.
- Write-back then refill, `LATENCY`=4:
  - `wr_mem`=1, `addr_mem`=9'h0A2 -> `ready_mem` low 4 cycles, then high. Drive 8'h11,22,33,44 -> mem[0A0..0A3] written.
  - Then `rd_mem`=1, `addr_mem`=9'h0A0 -> after 5 cycles, `data_mem` = 11,22,33,44 on consecutive cycles.
- Request held through HOLD:
  - Keep `rd_mem`=1 for 3 extra cycles after beat 3 -> no second burst; `ready_mem` stays 1, bus Z.
  - Drop `rd_mem` -> back to IDLE.
- Simultaneous request:
  - `rd_mem`=`wr_mem`=1 in IDLE -> write burst executed, not read.
  - `proto_err`=1 if `MEM_PROTO_CHK_EN` is defined.
- Reset mid-burst:
  - Assert `reset_n`=0 during WR_BURST beat 2 -> immediate `ready_mem`=1, IDLE; mem[base+2..3] unchanged.
- Block boundary:
  - `wr_mem` to 9'h1FF with data AA,BB,CC,DD -> writes mem[1FC..1FF].
  - Read of 9'h1FC returns AA,BB,CC,DD with no wrap into 9'h000.

Source files
------------

// File: rtl/mem_block_responder.sv
// mem_block_responder: main-memory model answering 4-beat block refills and
// write-backs from the cache's memory-side port over a shared data bus.
// Optional feature macro: MEM_PROTO_CHK_EN adds a sticky proto_err output
// flagging request lines that misbehave during a transaction.
module mem_block_responder #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic              rd_mem,
  input  logic              wr_mem,
  inout  wire  [DATA_W-1:0] data_mem,
  output logic              ready_mem
`ifdef MEM_PROTO_CHK_EN
  ,
  output logic              proto_err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_WAIT,
    WR_BURST,
    HOLD
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(3);

  state_t            state;
  state_t            state_next;
  logic [3:0]        lat_cnt;
  logic [1:0]        beat;
  logic [1:0]        rd_beat_next;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Beat addresses stay inside the aligned block: base low bits are zero,
  // so OR-ing the beat number in can never carry into the block address.
  assign rd_beat_next = (state == RD_BURST) ? beat + 2'd1 : 2'd0;
  assign rd_addr      = base | {{(ADDR_W-2){1'b0}}, rd_beat_next};
  assign wr_addr      = base | {{(ADDR_W-2){1'b0}}, beat};

  // The bus is released whenever the cache might be driving it.
  assign data_mem = (state == RD_BURST && !wr_mem) ? data_out : {DATA_W{1'bz}};

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and ready indication; write wins over read in IDLE.
  always_comb begin
    state_next = state;
    ready_mem  = 1'b1;
    case (state)
      IDLE: begin
        if (wr_mem) begin
          state_next = WR_WAIT;
        end else if (rd_mem) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        ready_mem = 1'b0;
        if (lat_cnt == LAT_LAST) begin
          state_next = RD_BURST;
        end
      end
      WR_WAIT: begin
        ready_mem = 1'b0;
        if (lat_cnt == LAT_LAST) begin
          state_next = WR_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (beat == 2'd3) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!rd_mem && !wr_mem) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Block base latch, latency and beat counters, and the registered read beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt  <= 4'd0;
      beat     <= 2'd0;
      base     <= '0;
      data_out <= '0;
    end else begin
      if (state == IDLE && (wr_mem || rd_mem)) begin
        base <= addr_mem & BLOCK_MASK;
      end
      if (state == RD_WAIT || state == WR_WAIT) begin
        lat_cnt <= (lat_cnt == LAT_LAST) ? 4'd0 : lat_cnt + 4'd1;
      end else begin
        lat_cnt <= 4'd0;
      end
      if (state == RD_BURST || state == WR_BURST) begin
        beat <= beat + 2'd1;
      end else begin
        beat <= 2'd0;
      end
      if (state_next == RD_BURST) begin
        data_out <= mem[rd_addr];
      end
    end
  end

  // Storage array capture during write bursts; contents survive reset.
  always_ff @(posedge clock) begin
    if (reset_n && state == WR_BURST) begin
      mem[wr_addr] <= data_mem;
    end
  end

`ifdef MEM_PROTO_CHK_EN
  // Sticky flag for request lines dropping mid-transaction or colliding in IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      proto_err <= 1'b0;
    end else begin
      if (((state == RD_WAIT || state == RD_BURST) && !rd_mem) ||
          ((state == WR_WAIT || state == WR_BURST) && !wr_mem) ||
          (state == IDLE && rd_mem && wr_mem)) begin
        proto_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
// tb_mem_block_responder: randomized and directed bench for the memory
// responder, checked against a byte-array model of main memory.
module tb_mem_block_responder;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int LAT    = 4;
  localparam logic [7:0] BUS_IDLE = 8'hFF;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] addr_mem;
  logic              rd_mem;
  logic              wr_mem;
  logic              ready_mem;
  logic              tb_drive;
  logic [DATA_W-1:0] tb_data;
  wire  [DATA_W-1:0] data_mem;
`ifdef MEM_PROTO_CHK_EN
  logic              proto_err;
`endif

  int checks = 0;
  int passes = 0;

  logic [7:0] ref_mem [512];
  int         written_bases[$];

  assign data_mem = tb_drive ? tb_data : 8'bz;

  for (genvar g = 0; g < DATA_W; g++) begin : g_pull
    pullup (data_mem[g]);
  end

  mem_block_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LATENCY(LAT)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .addr_mem (addr_mem),
    .rd_mem   (rd_mem),
    .wr_mem   (wr_mem),
    .data_mem (data_mem),
    .ready_mem(ready_mem)
`ifdef MEM_PROTO_CHK_EN
    ,
    .proto_err(proto_err)
`endif
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Model: a block write stores four bytes at the aligned base.
  task automatic model_write(input logic [8:0] addr, input logic [31:0] d);
    int b;
    b = int'(addr) / 4 * 4;
    for (int k = 0; k < 4; k++) ref_mem[b + k] = d[k*8 +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [8:0] addr);
    int b;
    logic [31:0] r;
    b = int'(addr) / 4 * 4;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = ref_mem[b + k];
    return r;
  endfunction

  // Bus driver: full write-back; returns number of cycles ready was low.
  task automatic wr_block(input logic [8:0] addr, input logic [31:0] d,
                          input logic rd_too, output int wait_cycles);
    addr_mem = addr;
    wr_mem = 1'b1;
    rd_mem = rd_too;
    @(posedge clock); #1;
    wait_cycles = 0;
    while (!ready_mem && wait_cycles < 40) begin
      wait_cycles++;
      @(posedge clock); #1;
    end
    for (int k = 0; k < 4; k++) begin
      tb_data = d[k*8 +: 8];
      tb_drive = 1'b1;
      @(posedge clock); #1;
    end
    tb_drive = 1'b0;
    wr_mem = 1'b0;
    rd_mem = 1'b0;
    addr_mem = $urandom;
    @(posedge clock); #1;
  endtask

  // Bus driver: full refill; holds rd_mem hold_extra cycles into HOLD and
  // counts HOLD cycles where ready dropped or the bus was driven.
  task automatic rd_block(input logic [8:0] addr, input int hold_extra,
                          output logic [31:0] d, output int wait_cycles,
                          output int hold_bad);
    addr_mem = addr;
    rd_mem = 1'b1;
    @(posedge clock); #1;
    addr_mem = $urandom;
    wait_cycles = 0;
    while (!ready_mem && wait_cycles < 40) begin
      wait_cycles++;
      @(posedge clock); #1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      d[k*8 +: 8] = data_mem;
      @(posedge clock); #1;
    end
    hold_bad = 0;
    for (int h = 0; h < hold_extra; h++) begin
      @(negedge clock);
      if (ready_mem !== 1'b1 || data_mem !== BUS_IDLE) hold_bad++;
      @(posedge clock); #1;
    end
    rd_mem = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rd_mem = 1'b0;
    wr_mem = 1'b0;
    tb_drive = 1'b0;
    tb_data = '0;
    addr_mem = '0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    checks++;
    if (ready_mem !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", ready_mem);
    else passes++;
    checks++;
    if (data_mem !== BUS_IDLE) $display("[TB] FAIL reset_bus: got %h expected %h", data_mem, BUS_IDLE);
    else passes++;
`ifdef MEM_PROTO_CHK_EN
    checks++;
    if (proto_err !== 1'b0) $display("[TB] FAIL reset_proto_err: got %b expected 0", proto_err);
    else passes++;
`endif
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (ready_mem !== 1'b1 || data_mem !== BUS_IDLE)
        $display("[TB] FAIL idle_after_reset: got ready=%b bus=%h expected ready=1 bus=%h",
                 ready_mem, data_mem, BUS_IDLE);
      else passes++;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_writeback_refill;
    int w, hb;
    logic [31:0] got, exp;
    wr_block(9'h0A2, 32'h44332211, 1'b0, w);
    model_write(9'h0A2, 32'h44332211);
    checks++;
    if (w !== LAT) $display("[TB] FAIL wr_latency: got %0d expected %0d", w, LAT);
    else passes++;
    rd_block(9'h0A0, 0, got, w, hb);
    exp = model_read(9'h0A0);
    checks++;
    if (w !== LAT) $display("[TB] FAIL rd_latency: got %0d expected %0d", w, LAT);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k*8 +: 8] !== exp[k*8 +: 8])
        $display("[TB] FAIL refill_beat%0d: got %h expected %h", k, got[k*8 +: 8], exp[k*8 +: 8]);
      else passes++;
    end
  endtask

  task automatic test_hold;
    int w, hb;
    logic [31:0] got;
    rd_block(9'h0A1, 3, got, w, hb);
    checks++;
    if (hb !== 0) $display("[TB] FAIL hold_no_rebust: got %0d bad cycles expected 0", hb);
    else passes++;
    @(negedge clock);
    checks++;
    if (ready_mem !== 1'b1) $display("[TB] FAIL hold_to_idle_ready: got %b expected 1", ready_mem);
    else passes++;
    @(posedge clock); #1;
    rd_block(9'h0A3, 0, got, w, hb);
    checks++;
    if (w !== LAT || got !== model_read(9'h0A0))
      $display("[TB] FAIL read_after_hold: got wait=%0d data=%h expected wait=%0d data=%h",
               w, got, LAT, model_read(9'h0A0));
    else passes++;
  endtask

  task automatic test_simultaneous;
    int w, hb;
    logic [31:0] d, got;
`ifdef MEM_PROTO_CHK_EN
    checks++;
    if (proto_err !== 1'b0) $display("[TB] FAIL proto_err_clean: got %b expected 0", proto_err);
    else passes++;
`endif
    d = 32'h8C5A3E17;
    wr_block(9'h051, d, 1'b1, w);
    model_write(9'h051, d);
    checks++;
    if (w !== LAT) $display("[TB] FAIL simul_latency: got %0d expected %0d", w, LAT);
    else passes++;
`ifdef MEM_PROTO_CHK_EN
    checks++;
    if (proto_err !== 1'b1) $display("[TB] FAIL proto_err_simul: got %b expected 1", proto_err);
    else passes++;
`endif
    rd_block(9'h050, 0, got, w, hb);
    checks++;
    if (got !== model_read(9'h050))
      $display("[TB] FAIL simul_write_wins: got %h expected %h", got, model_read(9'h050));
    else passes++;
  endtask

  task automatic test_reset_mid_burst;
    int w, hb;
    logic [31:0] got, nd;
    wr_block(9'h120, 32'h04030201, 1'b0, w);
    model_write(9'h120, 32'h04030201);
    nd = 32'h94939291;
    addr_mem = 9'h122;
    wr_mem = 1'b1;
    @(posedge clock); #1;
    w = 0;
    while (!ready_mem && w < 40) begin
      w++;
      @(posedge clock); #1;
    end
    for (int k = 0; k < 2; k++) begin
      tb_data = nd[k*8 +: 8];
      tb_drive = 1'b1;
      @(posedge clock); #1;
    end
    ref_mem[9'h120] = nd[7:0];
    ref_mem[9'h121] = nd[15:8];
    tb_data = nd[23:16];
    reset_n = 1'b0;
    #1;
    checks++;
    if (ready_mem !== 1'b1) $display("[TB] FAIL midreset_ready: got %b expected 1", ready_mem);
    else passes++;
    repeat (2) @(posedge clock);
    #1;
    tb_drive = 1'b0;
    wr_mem = 1'b0;
    #1;
    checks++;
    if (data_mem !== BUS_IDLE) $display("[TB] FAIL midreset_bus: got %h expected %h", data_mem, BUS_IDLE);
    else passes++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    rd_block(9'h120, 0, got, w, hb);
    checks++;
    if (got !== model_read(9'h120))
      $display("[TB] FAIL midreset_contents: got %h expected %h", got, model_read(9'h120));
    else passes++;
  endtask

  task automatic test_block_boundary;
    int w, hb;
    logic [31:0] got;
    wr_block(9'h002, 32'h5A6B7C0D, 1'b0, w);
    model_write(9'h002, 32'h5A6B7C0D);
    wr_block(9'h1FF, 32'hDDCCBBAA, 1'b0, w);
    model_write(9'h1FF, 32'hDDCCBBAA);
    rd_block(9'h1FC, 0, got, w, hb);
    checks++;
    if (got !== 32'hDDCCBBAA || got !== model_read(9'h1FC))
      $display("[TB] FAIL boundary_read: got %h expected %h", got, model_read(9'h1FC));
    else passes++;
    rd_block(9'h000, 0, got, w, hb);
    checks++;
    if (got !== model_read(9'h000))
      $display("[TB] FAIL boundary_no_wrap: got %h expected %h", got, model_read(9'h000));
    else passes++;
    written_bases.push_back(9'h1FC);
    written_bases.push_back(9'h000);
    written_bases.push_back(9'h0A0);
  endtask

  task automatic test_random;
    int w, hb, idx;
    logic [8:0] a;
    logic [31:0] d, got;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1) == 0) begin
        a = 9'($urandom_range(511));
        d = $urandom;
        wr_block(a, d, 1'b0, w);
        model_write(a, d);
        written_bases.push_back(int'(a) / 4 * 4);
        checks++;
        if (w !== LAT) $display("[TB] FAIL rand_wr_latency: got %0d expected %0d", w, LAT);
        else passes++;
      end else begin
        idx = $urandom_range(written_bases.size() - 1);
        a = 9'(written_bases[idx] + $urandom_range(3));
        rd_block(a, $urandom_range(2), got, w, hb);
        checks++;
        if (got !== model_read(a) || w !== LAT || hb !== 0)
          $display("[TB] FAIL rand_read %h: got data=%h wait=%0d holdbad=%0d expected data=%h wait=%0d holdbad=0",
                   a, got, w, hb, model_read(a), LAT);
        else passes++;
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_writeback_refill();
    test_hold();
    test_simultaneous();
    test_reset_mid_burst();
    test_block_boundary();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
